// File: rtl/mcu_cmd_dispatch.sv
// mcu_cmd_dispatch
//   Decodes MCU commands arriving as SSEL-framed byte messages from the SPI slave
//   (command byte followed by parameter bytes). It drives a single-outstanding
//   memory request port and supplies the next byte to be shifted out on MISO.
//
//   Optional feature macro: MCU_CMD_WRITE_CHECKSUM_EN
//     When defined, an 8-bit XOR of every acknowledged write byte is kept.
//     Status parameter 1 returns this checksum. When undefined, status
//     parameter 1 returns 8'h00.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_ready/cmd_data   command byte strobe and value
//   param_ready/param_data parameter byte strobe and value
//   endmessage           end of SSEL frame
//   spi_data_out         byte presented for the next SPI transfer
//   mem_req/we/addr/wdata  request toward the memory arbiter (held until ack)
//   mem_ack/mem_rdata    completion pulse and read data
//   feature_out          feature register
//   err_overrun          sticky: trigger dropped while a request was outstanding
//   err_timeout          sticky: request aborted after TIMEOUT cycles
module mcu_cmd_dispatch #(
  parameter int         ADDR_W  = 24,
  parameter logic [7:0] VERSION = 8'h01,
  parameter int         TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_ready,
  input  logic              param_ready,
  input  logic [7:0]        cmd_data,
  input  logic [7:0]        param_data,
  input  logic              endmessage,
  output logic [7:0]        spi_data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        feature_out,
  output logic              err_overrun,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    C_IDLE, C_SETADDR, C_READ, C_WRITE, C_FEAT, C_STATUS
  } cmd_state_t;

  typedef enum logic {
    M_IDLE, M_WAIT
  } mem_state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  cmd_state_t        cst_q, cst_d;
  mem_state_t        mst_q, mst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inc_en_q, inc_en_d;     // auto-increment mode of the current command
  logic              req_inc_q, req_inc_d;   // auto-increment mode of the in-flight request
  logic [2:0]        pcnt_q, pcnt_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        spi_q, spi_d;
  logic [7:0]        feat_q, feat_d;
  logic              err_ov_q, err_ov_d;
  logic              err_to_q, err_to_d;
`ifdef MCU_CMD_WRITE_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        ack;
  logic        timeout_hit;
  logic        can_issue;
  logic        issue;
  logic        issue_we;
  logic        issue_inc;
  logic [7:0]  issue_data;
  logic [23:0] addr24;

  // Only the opcode nibble and bit 0 of the command byte carry meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_data[3:1];

  always_comb begin
    cst_d       = cst_q;
    mst_d       = mst_q;
    addr_d      = addr_q;
    inc_en_d    = inc_en_q;
    req_inc_d   = req_inc_q;
    pcnt_d      = pcnt_q;
    tcnt_d      = tcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    spi_d       = spi_q;
    feat_d      = feat_q;
    err_ov_d    = err_ov_q;
    err_to_d    = err_to_q;
`ifdef MCU_CMD_WRITE_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    issue      = 1'b0;
    issue_we   = 1'b0;
    issue_inc  = 1'b0;
    issue_data = 8'h00;
    addr24     = 24'h0;

    ack         = (mst_q == M_WAIT) && mem_ack;
    // An ack in the final allowed cycle wins over the abort.
    timeout_hit = (mst_q == M_WAIT) && !mem_ack && (tcnt_q == TO_CNT);
    // A trigger coinciding with the ack is accepted and issued next cycle.
    can_issue   = (mst_q == M_IDLE) || ack;

    // Completion of the outstanding request.
    if (ack) begin
      mst_d     = M_IDLE;
      mem_req_d = 1'b0;
      if (!mem_we_q) begin
        spi_d = mem_rdata;
      end
`ifdef MCU_CMD_WRITE_CHECKSUM_EN
      else begin
        csum_d = csum_q ^ mem_wdata_q;
      end
`endif
      if (req_inc_q) begin
        addr_d = addr_q + 1'b1;
      end
    end else if (timeout_hit) begin
      mst_d     = M_IDLE;
      mem_req_d = 1'b0;
      err_to_d  = 1'b1;
    end else if (mst_q == M_WAIT) begin
      tcnt_d = tcnt_q + 8'd1;
    end

    if (cmd_ready) begin
      pcnt_d   = 3'd0;
      inc_en_d = ~cmd_data[0];
      unique case (cmd_data[7:4])
        4'h9: cst_d = C_SETADDR;
        4'h8: begin
          cst_d = C_READ;
          // Prefetch so the first read byte is ready for the next transfer.
          if (can_issue) begin
            issue     = 1'b1;
            issue_inc = ~cmd_data[0];
          end
        end
        4'hA: cst_d = C_WRITE;
        4'hE: cst_d = C_FEAT;
        4'hF: begin
          cst_d = C_STATUS;
          spi_d = VERSION;
        end
        4'hC: begin
          cst_d    = C_IDLE;
          err_ov_d = 1'b0;
          err_to_d = 1'b0;
`ifdef MCU_CMD_WRITE_CHECKSUM_EN
          csum_d   = 8'h00;
`endif
        end
        default: cst_d = C_IDLE;
      endcase
    end else if (endmessage) begin
      // Frame closed: nothing further is issued, an in-flight request still completes.
      cst_d = C_IDLE;
    end else if (param_ready) begin
      pcnt_d = (pcnt_q == 3'd7) ? 3'd7 : pcnt_q + 3'd1;
      unique case (cst_q)
        C_SETADDR: begin
          addr24 = 24'(addr_d);
          if (pcnt_q == 3'd0) addr24[23:16] = param_data;
          if (pcnt_q == 3'd1) addr24[15:8]  = param_data;
          if (pcnt_q == 3'd2) addr24[7:0]   = param_data;
          addr_d = ADDR_W'(addr24);
        end
        C_READ, C_WRITE: begin
          if (can_issue) begin
            issue      = 1'b1;
            issue_we   = (cst_q == C_WRITE);
            issue_data = (cst_q == C_WRITE) ? param_data : 8'h00;
            issue_inc  = inc_en_q;
          end else begin
            err_ov_d = 1'b1;
          end
        end
        C_FEAT: begin
          if (pcnt_q == 3'd0) feat_d = param_data;
        end
        C_STATUS: begin
          if (pcnt_q == 3'd0) begin
            spi_d = {6'b0, err_to_q, err_ov_q};
          end else if (pcnt_q == 3'd1) begin
`ifdef MCU_CMD_WRITE_CHECKSUM_EN
            spi_d = csum_q;
`else
            spi_d = 8'h00;
`endif
          end else begin
            spi_d = 8'h00;
          end
        end
        default: ;
      endcase
    end

    // The request uses the address after any increment from a coincident ack.
    if (issue) begin
      mst_d       = M_WAIT;
      mem_req_d   = 1'b1;
      mem_we_d    = issue_we;
      mem_addr_d  = addr_d;
      mem_wdata_d = issue_data;
      req_inc_d   = issue_inc;
      tcnt_d      = 8'd1;   // counts cycles with mem_req high, this one included
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst_q       <= C_IDLE;
      mst_q       <= M_IDLE;
      addr_q      <= '0;
      inc_en_q    <= 1'b0;
      req_inc_q   <= 1'b0;
      pcnt_q      <= 3'd0;
      tcnt_q      <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      spi_q       <= 8'h00;
      feat_q      <= 8'h00;
      err_ov_q    <= 1'b0;
      err_to_q    <= 1'b0;
`ifdef MCU_CMD_WRITE_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      cst_q       <= cst_d;
      mst_q       <= mst_d;
      addr_q      <= addr_d;
      inc_en_q    <= inc_en_d;
      req_inc_q   <= req_inc_d;
      pcnt_q      <= pcnt_d;
      tcnt_q      <= tcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      spi_q       <= spi_d;
      feat_q      <= feat_d;
      err_ov_q    <= err_ov_d;
      err_to_q    <= err_to_d;
`ifdef MCU_CMD_WRITE_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign spi_data_out = spi_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign feature_out  = feat_q;
  assign err_overrun  = err_ov_q;
  assign err_timeout  = err_to_q;

endmodule
